eth_phy_10g_rx_slip_ctrl: RTL and testbench
===========================================

// Module: eth_phy_10g_rx_slip_ctrl
// PURPOSE
//  Block-lock controller for the 10G RX path: checks each 2-bit sync header from the SERDES/gearbox and drives a
//  one-cycle bitslip request until headers are stable. Sits between the SERDES RX gearbox and the RX aligner/decoder.
//  Its rx_block_lock output gates downstream decoding.
// PARAMETERS
//  HDR_WIDTH       2   sync header width; only 2 is supported, any other value -> $error at elaboration
//  SH_WINDOW_LOG2  6   log2 of the header window size (64 headers)
//  MAX_INVALID     16  invalid headers in one window that drop lock (1..2**SH_WINDOW_LOG2)
//  SLIP_WAIT       32  cycles for which headers are ignored after each slip (>=1)
//  MAX_SLIPS       66  slips without lock before align_fail is raised (<=127)
// PORTS
//  clk                input   1          core clock; all logic on rising edge
//  rst_n              input   1          asynchronous, active-low reset
//  enable             input   1          0: hold in HUNT, no slips, counters cleared
//  serdes_rx_valid    input   1          header/data valid this cycle (gearbox pause when 0)
//  serdes_rx_hdr      input   HDR_WIDTH  sync header; valid = 2'b01 or 2'b10
//  serdes_rx_bitslip  output  1          one-cycle pulse requesting a 1-bit slip
//  rx_block_lock      output  1          1 while in LOCKED
//  slip_count         output  7          slips since last lock/enable; saturates at 127
//  align_fail         output  1          sticky: slip_count reached MAX_SLIPS; cleared by lock, !enable, reset
//  lock_loss_count    output  16         lock-loss events (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=HUNT; all counters 0; every output 0.
//  - Header evaluation happens only when serdes_rx_valid=1 and the state is not SLIP_WAIT.
//    A valid header is 01 or 10; 00 and 11 are invalid.
//  - All outputs are registered: the response appears 1 cycle after the header sample that causes it.
//  - HUNT:
//    - Each valid header increments sh_cnt. When the count reaches 2**SH_WINDOW_LOG2 consecutive valid headers,
//      go to LOCKED: rx_block_lock=1, slip_count=0, align_fail=0.
//    - An invalid header pulses bitslip for 1 cycle, sets sh_cnt=0, increments slip_count and enters SLIP_WAIT.
//  - SLIP_WAIT: a wait counter counts SLIP_WAIT cycles regardless of valid; headers are ignored; then go to HUNT.
//    No second slip can occur within SLIP_WAIT+1 cycles of the previous one.
//  - LOCKED:
//    - Each evaluated header increments win_cnt; invalid headers also increment inv_cnt.
//    - When inv_cnt reaches MAX_INVALID: drop lock (rx_block_lock=0 on the next cycle), pulse bitslip,
//      increment lock_loss_count, enter SLIP_WAIT.
//    - When the window completes (win_cnt wraps) with inv_cnt<MAX_INVALID, clear both counters and stay LOCKED.
//    - If the last header of the window is also the MAX_INVALID-th invalid header, lock loss takes priority.
//  - align_fail sets when slip_count==MAX_SLIPS. Slipping continues: slip_count keeps rising and saturates at 127.
//  - enable=0 from any state: next state HUNT; sh/win/inv/wait counters, slip_count and align_fail cleared;
//    bitslip=0. lock_loss_count is kept.
//  - serdes_rx_valid=0: counters hold, except the SLIP_WAIT timer, which keeps running.
//  - Reset asserted mid-SLIP_WAIT or mid-LOCKED aborts immediately into the reset state.
// CONFIGURATION
//  RX_SLIP_STATS_EN defined:
//    lock_loss_count is a 16-bit counter that saturates at 16'hFFFF. Cleared only by reset.
//  RX_SLIP_STATS_EN undefined:
//    lock_loss_count is tied to 16'h0000 and no counter flops are inferred.
// TESTING
//  1. Reset, enable=1, 64 valid headers (01/10 mixed) -> rx_block_lock=1 one cycle after header 64; bitslip never.
//  2. Header 00 in HUNT -> bitslip=1 for exactly 1 cycle, slip_count=1. With SLIP_WAIT=32, headers 00 on the
//     next 32 cycles -> no slip; the first 00 after the wait -> 2nd slip.
//  3. Locked; 15 invalid in one window, then window end -> lock held. Next window 16 invalid -> lock drops,
//     bitslip pulse, lock_loss_count=1 (0 with the macro undefined).
//  4. Only invalid headers for 66 slip attempts -> align_fail=1 after the 66th slip. Then 64 valid -> lock,
//     align_fail=0, slip_count=0.
//  5. serdes_rx_valid toggling 50% with valid headers -> lock after 64 valid-qualified headers (~128 cycles).
//  6. enable=0 mid-SLIP_WAIT -> HUNT next cycle, no bitslip, slip_count=0. Async rst_n pulse while LOCKED
//     -> rx_block_lock=0 with no clock edge.

Source files
------------

// File: rtl/eth_phy_10g_rx_slip_ctrl.sv
// 10G RX block-lock controller: sync-header checking with bitslip requests.
// Define RX_SLIP_STATS_EN to enable the saturating lock-loss event counter.
module eth_phy_10g_rx_slip_ctrl #(
    parameter int HDR_WIDTH      = 2,
    parameter int SH_WINDOW_LOG2 = 6,
    parameter int MAX_INVALID    = 16,
    parameter int SLIP_WAIT      = 32,
    parameter int MAX_SLIPS      = 66
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 serdes_rx_valid,
    input  logic [HDR_WIDTH-1:0] serdes_rx_hdr,
    output logic                 serdes_rx_bitslip,
    output logic                 rx_block_lock,
    output logic [6:0]           slip_count,
    output logic                 align_fail,
    output logic [15:0]          lock_loss_count
);

    localparam int SW = SH_WINDOW_LOG2;
    localparam int WW = $clog2(SLIP_WAIT + 1);

    localparam logic [SW-1:0] WIN_LAST  = '1;
    localparam logic [SW-1:0] INV_LAST  = SW'(MAX_INVALID - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(SLIP_WAIT - 1);
    localparam logic [6:0]    SLIPS_MAX = 7'(MAX_SLIPS);

    if (HDR_WIDTH != 2) begin : g_bad_hdr_width
        $error("eth_phy_10g_rx_slip_ctrl: HDR_WIDTH must be 2");
    end

    if (MAX_INVALID < 1 || MAX_INVALID > (1 << SH_WINDOW_LOG2)) begin : g_bad_max_inv
        $error("eth_phy_10g_rx_slip_ctrl: MAX_INVALID out of range");
    end

    if (SLIP_WAIT < 1) begin : g_bad_slip_wait
        $error("eth_phy_10g_rx_slip_ctrl: SLIP_WAIT must be >= 1");
    end

    if (MAX_SLIPS > 127) begin : g_bad_max_slips
        $error("eth_phy_10g_rx_slip_ctrl: MAX_SLIPS must be <= 127");
    end

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_SLIP_WAIT,
        ST_LOCKED
    } state_t;

    state_t        state;
    state_t        state_d;
    logic [SW-1:0] sh_cnt;
    logic [SW-1:0] sh_d;
    logic [SW-1:0] win_cnt;
    logic [SW-1:0] win_d;
    logic [SW-1:0] inv_cnt;
    logic [SW-1:0] inv_d;
    logic [WW-1:0] wait_cnt;
    logic [WW-1:0] wait_d;
    logic [6:0]    slip_d;
    logic [6:0]    slip_inc;
    logic          fail_d;
    logic          bitslip_d;
    logic          hdr_ok;
    logic          lose_lock;

    assign hdr_ok    = ^serdes_rx_hdr[1:0];
    assign slip_inc  = (slip_count == 7'h7F) ? slip_count : slip_count + 7'd1;
    // The MAX_INVALID-th bad header wins over a simultaneous window wrap.
    assign lose_lock = serdes_rx_valid && !hdr_ok && (inv_cnt == INV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= ST_HUNT;
            sh_cnt            <= '0;
            win_cnt           <= '0;
            inv_cnt           <= '0;
            wait_cnt          <= '0;
            slip_count        <= '0;
            align_fail        <= 1'b0;
            serdes_rx_bitslip <= 1'b0;
            rx_block_lock     <= 1'b0;
        end else begin
            state             <= state_d;
            sh_cnt            <= sh_d;
            win_cnt           <= win_d;
            inv_cnt           <= inv_d;
            wait_cnt          <= wait_d;
            slip_count        <= slip_d;
            align_fail        <= fail_d;
            serdes_rx_bitslip <= bitslip_d;
            rx_block_lock     <= (state_d == ST_LOCKED);
        end
    end

    always_comb begin
        state_d   = state;
        sh_d      = sh_cnt;
        win_d     = win_cnt;
        inv_d     = inv_cnt;
        wait_d    = wait_cnt;
        slip_d    = slip_count;
        fail_d    = align_fail;
        bitslip_d = 1'b0;

        if (!enable) begin
            state_d = ST_HUNT;
            sh_d    = '0;
            win_d   = '0;
            inv_d   = '0;
            wait_d  = '0;
            slip_d  = '0;
            fail_d  = 1'b0;
        end else begin
            unique case (state)
                ST_HUNT: begin
                    if (serdes_rx_valid && hdr_ok) begin
                        if (sh_cnt == WIN_LAST) begin
                            state_d = ST_LOCKED;
                            sh_d    = '0;
                            win_d   = '0;
                            inv_d   = '0;
                            slip_d  = '0;
                            fail_d  = 1'b0;
                        end else begin
                            sh_d = sh_cnt + SW'(1);
                        end
                    end else if (serdes_rx_valid) begin
                        state_d   = ST_SLIP_WAIT;
                        bitslip_d = 1'b1;
                        sh_d      = '0;
                        wait_d    = '0;
                        slip_d    = slip_inc;
                        fail_d    = align_fail | (slip_inc == SLIPS_MAX);
                    end
                end
                ST_SLIP_WAIT: begin
                    // Timer runs on every cycle, valid or not.
                    if (wait_cnt == WAIT_LAST) begin
                        state_d = ST_HUNT;
                        wait_d  = '0;
                    end else begin
                        wait_d = wait_cnt + WW'(1);
                    end
                end
                ST_LOCKED: begin
                    if (lose_lock) begin
                        state_d   = ST_SLIP_WAIT;
                        bitslip_d = 1'b1;
                        win_d     = '0;
                        inv_d     = '0;
                        wait_d    = '0;
                        slip_d    = slip_inc;
                        fail_d    = align_fail | (slip_inc == SLIPS_MAX);
                    end else if (serdes_rx_valid) begin
                        if (win_cnt == WIN_LAST) begin
                            win_d = '0;
                            inv_d = '0;
                        end else begin
                            win_d = win_cnt + SW'(1);
                            inv_d = hdr_ok ? inv_cnt : inv_cnt + SW'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                end
            endcase
        end
    end

`ifdef RX_SLIP_STATS_EN
    logic loss_ev;

    assign loss_ev = enable && (state == ST_LOCKED) && lose_lock;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_loss_count <= '0;
        end else if (loss_ev && (lock_loss_count != 16'hFFFF)) begin
            lock_loss_count <= lock_loss_count + 16'd1;
        end
    end
`else
    assign lock_loss_count = 16'h0000;
`endif

endmodule

// File: tb/tb_eth_phy_10g_rx_slip_ctrl.sv
// Bench for eth_phy_10g_rx_slip_ctrl: directed scenarios plus randomized traffic
// checked every cycle against an event-timed behavioural model.
module tb_eth_phy_10g_rx_slip_ctrl;

    localparam int WIN    = 64;
    localparam int MAXINV = 16;
    localparam int WAITC  = 32;
    localparam int MAXSL  = 66;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        serdes_rx_valid = 1'b0;
    logic [1:0]  serdes_rx_hdr = 2'b00;
    logic        serdes_rx_bitslip;
    logic        rx_block_lock;
    logic [6:0]  slip_count;
    logic        align_fail;
    logic [15:0] lock_loss_count;

    int total = 0;
    int bad = 0;

    eth_phy_10g_rx_slip_ctrl dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .enable            (enable),
        .serdes_rx_valid   (serdes_rx_valid),
        .serdes_rx_hdr     (serdes_rx_hdr),
        .serdes_rx_bitslip (serdes_rx_bitslip),
        .rx_block_lock     (rx_block_lock),
        .slip_count        (slip_count),
        .align_fail        (align_fail),
        .lock_loss_count   (lock_loss_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: time is an edge index; a slip at edge c makes edges c+1..c+WAITC deaf.
    int m_cyc = 0;
    int m_hold = -1;
    bit m_locked = 0;
    int m_run = 0;
    int m_seen = 0;
    int m_bad = 0;
    int m_slips = 0;
    bit m_fail = 0;
    int m_losses = 0;
    bit m_pulse = 0;

    task automatic m_clear();
        m_locked = 0; m_run = 0; m_seen = 0; m_bad = 0;
        m_slips = 0; m_fail = 0; m_hold = -1; m_pulse = 0;
    endtask

    task automatic m_slip();
        m_pulse = 1; m_run = 0; m_seen = 0; m_bad = 0;
        if (m_slips < 127) m_slips++;
        if (m_slips == MAXSL) m_fail = 1;
        m_hold = m_cyc + WAITC;
    endtask

    task automatic m_step(input logic e, input logic v, input logic [1:0] h);
        bit good;
        good = (h == 2'b01) || (h == 2'b10);
        m_pulse = 0;
        if (!e) begin
            m_clear();
        end else if (m_cyc > m_hold && v) begin
            if (!m_locked) begin
                if (good) begin
                    m_run++;
                    if (m_run == WIN) begin
                        m_locked = 1; m_run = 0; m_slips = 0; m_fail = 0;
                        m_seen = 0; m_bad = 0;
                    end
                end else begin
                    m_slip();
                end
            end else begin
                m_seen++;
                if (!good) m_bad++;
                if (m_bad == MAXINV) begin
                    m_locked = 0;
`ifdef RX_SLIP_STATS_EN
                    if (m_losses < 65535) m_losses++;
`endif
                    m_slip();
                end else if (m_seen == WIN) begin
                    m_seen = 0; m_bad = 0;
                end
            end
        end
        m_cyc++;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_clear();
            m_losses = 0;
        end else begin
            m_step(enable, serdes_rx_valid, serdes_rx_hdr);
        end
    end

    always @(negedge clk) begin
        chk("bitslip", int'(serdes_rx_bitslip), int'(m_pulse));
        chk("lock", int'(rx_block_lock), int'(m_locked));
        chk("slip_count", int'(slip_count), m_slips);
        chk("align_fail", int'(align_fail), int'(m_fail));
        chk("lock_loss", int'(lock_loss_count), m_losses);
    end

    task automatic step(input logic e, input logic v, input logic [1:0] h);
        enable = e;
        serdes_rx_valid = v;
        serdes_rx_hdr = h;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] good_h();
        return ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [1:0] bad_h();
        return ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11;
    endfunction

    int exp_loss1;
    int pbad;

    initial begin
`ifdef RX_SLIP_STATS_EN
        exp_loss1 = 1;
`else
        exp_loss1 = 0;
`endif
        repeat (3) step(1'b1, 1'b1, 2'b00);
        chk("rst_bitslip", int'(serdes_rx_bitslip), 0);
        chk("rst_lock", int'(rx_block_lock), 0);
        chk("rst_slips", int'(slip_count), 0);
        chk("rst_fail", int'(align_fail), 0);
        chk("rst_loss", int'(lock_loss_count), 0);
        rst_n = 1'b1;

        // Acquire lock on 64 good headers
        repeat (WIN - 1) step(1'b1, 1'b1, good_h());
        chk("t1_no_lock_63", int'(rx_block_lock), 0);
        step(1'b1, 1'b1, good_h());
        chk("t1_lock_64", int'(rx_block_lock), 1);

        // 15 bad in a window keeps lock; 16 bad in the next drops it
        for (int i = 0; i < WIN; i++)
            step(1'b1, 1'b1, (i % 4 == 1 && i < 60) ? bad_h() : good_h());
        chk("t3_lock_held", int'(rx_block_lock), 1);
        for (int i = 0; i <= 45; i++)
            step(1'b1, 1'b1, (i % 3 == 0) ? bad_h() : good_h());
        chk("t3_lock_drop", int'(rx_block_lock), 0);
        chk("t3_bitslip", int'(serdes_rx_bitslip), 1);
        chk("t3_loss", int'(lock_loss_count), exp_loss1);

        // Slip spacing
        step(1'b0, 1'b0, 2'b00);
        step(1'b1, 1'b1, 2'b00);
        chk("t2_slip1", int'(serdes_rx_bitslip), 1);
        chk("t2_count1", int'(slip_count), 1);
        step(1'b1, 1'b1, 2'b00);
        chk("t2_pulse_1cyc", int'(serdes_rx_bitslip), 0);
        repeat (WAITC - 1) step(1'b1, 1'b1, 2'b00);
        chk("t2_no_slip_wait", int'(serdes_rx_bitslip), 0);
        step(1'b1, 1'b1, 2'b00);
        chk("t2_slip2", int'(serdes_rx_bitslip), 1);
        chk("t2_count2", int'(slip_count), 2);

        // align_fail after 66 slips, saturation at 127, then relock
        step(1'b0, 1'b0, 2'b00);
        repeat ((WAITC + 1) * 64 + 1) step(1'b1, 1'b1, bad_h());
        chk("t4_slips65", int'(slip_count), 65);
        chk("t4_fail_pre", int'(align_fail), 0);
        repeat (WAITC + 1) step(1'b1, 1'b1, bad_h());
        chk("t4_slips66", int'(slip_count), 66);
        chk("t4_fail", int'(align_fail), 1);
        repeat ((WAITC + 1) * 70) step(1'b1, 1'b1, bad_h());
        chk("t4_sat", int'(slip_count), 127);
        chk("t4_fail_sticky", int'(align_fail), 1);
        repeat (WAITC) step(1'b1, $urandom_range(0, 1) != 0, bad_h());
        repeat (WIN) step(1'b1, 1'b1, good_h());
        chk("t4_relock", int'(rx_block_lock), 1);
        chk("t4_fail_clr", int'(align_fail), 0);
        chk("t4_slips_clr", int'(slip_count), 0);

        // 16th bad header on the window's last slot still drops lock
        for (int i = 0; i < WIN; i++)
            step(1'b1, 1'b1, (i < MAXINV - 1 || i == WIN - 1) ? bad_h() : good_h());
        chk("prio_drop", int'(rx_block_lock), 0);
        chk("prio_slip", int'(serdes_rx_bitslip), 1);

        // Valid toggling: bad headers while not valid are ignored
        step(1'b0, 1'b0, 2'b00);
        for (int i = 0; i < 2 * WIN; i++) begin
            step(1'b1, i[0], i[0] ? good_h() : bad_h());
            if (i == 2 * WIN - 2) chk("t5_no_lock", int'(rx_block_lock), 0);
        end
        chk("t5_lock", int'(rx_block_lock), 1);

        // enable drop mid-wait, then async reset while locked
        step(1'b0, 1'b0, 2'b00);
        step(1'b1, 1'b1, bad_h());
        repeat (10) step(1'b1, 1'b1, bad_h());
        step(1'b0, 1'b1, 2'b00);
        chk("t6_no_slip", int'(serdes_rx_bitslip), 0);
        chk("t6_slips0", int'(slip_count), 0);
        repeat (WIN) step(1'b1, 1'b1, good_h());
        chk("t6_locked", int'(rx_block_lock), 1);
        #2 rst_n = 1'b0;
        #1 chk("t6_async_rst", int'(rx_block_lock), 0);
        step(1'b1, 1'b1, good_h());
        step(1'b1, 1'b1, good_h());
        rst_n = 1'b1;

        // Randomized traffic in segments of varying error density
        for (int s = 0; s < 24; s++) begin
            case ($urandom_range(0, 3))
                0: pbad = 0;
                1: pbad = 3;
                2: pbad = 30;
                default: pbad = 70;
            endcase
            for (int i = 0; i < 200; i++)
                step($urandom_range(0, 99) < 98,
                     $urandom_range(0, 99) < 85,
                     ($urandom_range(0, 99) < pbad) ? bad_h() : good_h());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
